// File: rtl/rmw_fwd_pipe_if.sv
// Signal bundle between rmw_fwd_pipe and its issue source, state memory and application datapath.
// The block only ever sees the slave view; the master view is the environment side.
interface rmw_fwd_pipe_if #(
    parameter int PORT_W = 5,
    parameter int MEM_DW = 10,
    parameter int CAL_DW = 10,
    parameter int CNT_W  = 16
);
    // Valid-only qualifiers: each *_vld marks its companion fields for that single cycle.
    // There is no ready; every valid beat is consumed in the cycle it is presented.
    logic              i_port_vld;
    logic [PORT_W-1:0] i_port_id;
    logic [MEM_DW-1:0] i_mem_rdata;
    logic              o_app_vld;
    logic [PORT_W-1:0] o_app_port_id;
    logic [MEM_DW-1:0] o_app_rdata;
    logic [MEM_DW-1:0] i_app_wdata;
    logic              i_draw_back;
    logic [CAL_DW-1:0] i_app_cal_data;
    logic              o_mem_wvld;
    logic [PORT_W-1:0] o_mem_waddr;
    logic [MEM_DW-1:0] o_mem_wdata;
    logic              o_down_vld;
    logic [CAL_DW-1:0] o_down_cal_data;
    logic              o_fwd_hit;
    logic [CNT_W-1:0]  o_fwd_hit_cnt;

    modport slave (
        input  i_port_vld, i_port_id, i_mem_rdata, i_app_wdata, i_draw_back, i_app_cal_data,
        output o_app_vld, o_app_port_id, o_app_rdata, o_mem_wvld, o_mem_waddr, o_mem_wdata,
               o_down_vld, o_down_cal_data, o_fwd_hit, o_fwd_hit_cnt
    );

    modport master (
        output i_port_vld, i_port_id, i_mem_rdata, i_app_wdata, i_draw_back, i_app_cal_data,
        input  o_app_vld, o_app_port_id, o_app_rdata, o_mem_wvld, o_mem_waddr, o_mem_wdata,
               o_down_vld, o_down_cal_data, o_fwd_hit, o_fwd_hit_cnt
    );
endinterface

// File: rtl/rmw_fwd_pipe.sv
// Per-port read-modify-write pipeline: forwards committed-but-not-yet-visible writes to
// stage S for any memory read latency, with per-op draw-back and a forward-hit counter.
module rmw_fwd_pipe #(
    parameter int PORT_N = 20,
    parameter int PORT_W = (PORT_N == 1) ? 1 : $clog2(PORT_N),
    parameter int MEM_DW = 10,
    parameter int CAL_DW = 10,
    parameter int RD_LAT = 1,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    rmw_fwd_pipe_if.slave bus
);
    localparam int H = RD_LAT + 1;

    logic [RD_LAT-1:0] iss_vld_q, iss_vld_d;
    logic [PORT_W-1:0] iss_id_q [RD_LAT];
    logic [PORT_W-1:0] iss_id_d [RD_LAT];

    logic              app_vld;
    logic [PORT_W-1:0] app_id;
    logic              commit;

    logic [H-1:0]      hist_vld_q, hist_vld_d;
    logic [PORT_W-1:0] hist_id_q   [H];
    logic [PORT_W-1:0] hist_id_d   [H];
    logic [MEM_DW-1:0] hist_data_q [H];
    logic [MEM_DW-1:0] hist_data_d [H];

    logic              fwd_match;
    logic [MEM_DW-1:0] fwd_data;
    logic              fwd_hit;

    logic              mem_wvld_q, mem_wvld_d;
    logic [PORT_W-1:0] mem_waddr_q, mem_waddr_d;
    logic [MEM_DW-1:0] mem_wdata_q, mem_wdata_d;
    logic              down_vld_q, down_vld_d;
    logic [CAL_DW-1:0] down_cal_q, down_cal_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Issue pipe: id registers only move alongside a valid, so idle slots keep stale ids.
    always_comb begin
        iss_vld_d    = '0;
        iss_vld_d[0] = bus.i_port_vld;
        iss_id_d[0]  = bus.i_port_vld ? bus.i_port_id : iss_id_q[0];
        for (int i = 1; i < RD_LAT; i++) begin
            iss_vld_d[i] = iss_vld_q[i-1];
            iss_id_d[i]  = iss_vld_q[i-1] ? iss_id_q[i-1] : iss_id_q[i];
        end
    end

    assign app_vld = iss_vld_q[RD_LAT-1];
    assign app_id  = iss_id_q[RD_LAT-1];
    assign commit  = app_vld & ~bus.i_draw_back;

    always_comb begin
        hist_vld_d     = {hist_vld_q[H-2:0], commit};
        hist_id_d[0]   = app_id;
        hist_data_d[0] = bus.i_app_wdata;
        for (int i = 1; i < H; i++) begin
            hist_id_d[i]   = hist_id_q[i-1];
            hist_data_d[i] = hist_data_q[i-1];
        end
    end

    // Scan oldest to youngest so the youngest matching commit wins.
    always_comb begin
        fwd_match = 1'b0;
        fwd_data  = bus.i_mem_rdata;
        if (FWD_EN != 0) begin
            for (int i = H - 1; i >= 0; i--) begin
                if (hist_vld_q[i] && (hist_id_q[i] == app_id)) begin
                    fwd_match = 1'b1;
                    fwd_data  = hist_data_q[i];
                end
            end
        end
    end

    assign fwd_hit = app_vld & fwd_match;

    always_comb begin
        mem_wvld_d  = commit;
        mem_waddr_d = commit ? app_id : mem_waddr_q;
        mem_wdata_d = commit ? bus.i_app_wdata : mem_wdata_q;
        down_vld_d  = commit;
        down_cal_d  = commit ? bus.i_app_cal_data : down_cal_q;
        cnt_d       = (fwd_hit && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            iss_vld_q  <= '0;
            hist_vld_q <= '0;
            mem_wvld_q <= 1'b0;
            down_vld_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            iss_vld_q  <= iss_vld_d;
            hist_vld_q <= hist_vld_d;
            mem_wvld_q <= mem_wvld_d;
            down_vld_q <= down_vld_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        iss_id_q    <= iss_id_d;
        hist_id_q   <= hist_id_d;
        hist_data_q <= hist_data_d;
        mem_waddr_q <= mem_waddr_d;
        mem_wdata_q <= mem_wdata_d;
        down_cal_q  <= down_cal_d;
    end

    assign bus.o_app_vld       = app_vld;
    assign bus.o_app_port_id   = app_id;
    assign bus.o_app_rdata     = fwd_data;
    assign bus.o_fwd_hit       = fwd_hit;
    assign bus.o_mem_wvld      = mem_wvld_q;
    assign bus.o_mem_waddr     = mem_waddr_q;
    assign bus.o_mem_wdata     = mem_wdata_q;
    assign bus.o_down_vld      = down_vld_q;
    assign bus.o_down_cal_data = down_cal_q;
    assign bus.o_fwd_hit_cnt   = cnt_q;
endmodule

// File: tb/tb_rmw_fwd_pipe.sv
// Bench for rmw_fwd_pipe: three instances (RD_LAT=2, RD_LAT=1, RD_LAT=2 without forwarding)
// share one stimulus stream; each has its own state memory, app model and scoreboard.
module tb_rmw_fwd_pipe;
  localparam int PN = 20, PW = 5, DW = 10, CW = 10, CNTW = 16, NI = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic drv_vld = 1'b0;
  logic [PW-1:0] drv_id = '0;
  logic drv_draw = 1'b0;
  logic [CW-1:0] drv_cal = '0;
  logic pre_we = 1'b0;
  logic [PW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  logic drain_chk = 1'b0;
  logic [NI-1:0][CNTW-1:0] cnt_obs;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int LAT = (g == 1) ? 1 : 2;
    localparam int FEN = (g == 2) ? 0 : 1;

    rmw_fwd_pipe_if #(.PORT_W(PW), .MEM_DW(DW), .CAL_DW(CW), .CNT_W(CNTW)) bus ();

    rmw_fwd_pipe #(
      .PORT_N(PN), .PORT_W(PW), .MEM_DW(DW), .CAL_DW(CW),
      .RD_LAT(LAT), .FWD_EN(FEN), .CNT_W(CNTW)
    ) u_dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .bus    (bus.slave)
    );

    logic [DW-1:0] mem [PN];
    logic [DW-1:0] rd_pipe [LAT];
    logic [DW-1:0] arch [PN];
    int last_commit [PN];
    int cyc = 0;
    logic armed = 1'b0, rst_seen = 1'b0, resync = 1'b1;
    logic [DW-1:0] er, wd;
    logic eh, d_draw;
    logic [CW-1:0] d_cal;
    logic [PW+DW-1:0] w;
    logic [CNTW-1:0] exp_cnt = '0;
    logic [DW-1:0] exp_rd_q[$];
    logic exp_hit_q[$];
    logic draw_q[$];
    logic [CW-1:0] cal_q[$];
    logic [PW+DW-1:0] exp_wr_q[$];
    logic [CW-1:0] exp_dn_q[$];

    assign bus.i_port_vld  = drv_vld;
    assign bus.i_port_id   = drv_id;
    assign bus.i_mem_rdata = rd_pipe[LAT-1];
    assign cnt_obs[g]      = bus.o_fwd_hit_cnt;

    initial forever begin
      @(posedge clk or negedge clk);
      if (clk) begin
        // state memory: a read captures the contents before this edge's write
        if (bus.o_mem_wvld === 1'b1) mem[bus.o_mem_waddr] <= bus.o_mem_wdata;
        if (pre_we) mem[pre_addr] <= pre_data;
        if (bus.i_port_vld) rd_pipe[0] <= mem[bus.i_port_id];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        cyc++;
        if (!rst_n) begin
          armed = 1'b1; rst_seen = 1'b1; resync = 1'b1; exp_cnt = '0;
          exp_rd_q.delete(); exp_hit_q.delete(); draw_q.delete(); cal_q.delete();
          exp_wr_q.delete(); exp_dn_q.delete();
        end else begin
          if (resync) begin
            for (int i = 0; i < PN; i++) begin
              arch[i] = mem[i];
              last_commit[i] = -100;
            end
            resync = 1'b0;
          end
          if (pre_we) arch[pre_addr] = pre_data;
          if (drv_vld) begin
            er = (FEN != 0) ? arch[drv_id] : mem[drv_id];
            eh = (FEN != 0) && ((cyc - last_commit[drv_id]) <= LAT + 1);
            exp_rd_q.push_back(er); exp_hit_q.push_back(eh);
            draw_q.push_back(drv_draw); cal_q.push_back(drv_cal);
            if (!drv_draw) begin
              wd = er + 1'b1;
              arch[drv_id] = wd;
              last_commit[drv_id] = cyc;
              exp_wr_q.push_back({drv_id, wd});
              exp_dn_q.push_back(drv_cal);
            end
          end
        end
      end else if (armed) begin
        if (rst_seen) begin
          check_val($sformatf("i%0d_rst_app_vld", g), bus.o_app_vld, 0);
          check_val($sformatf("i%0d_rst_mem_wvld", g), bus.o_mem_wvld, 0);
          check_val($sformatf("i%0d_rst_down_vld", g), bus.o_down_vld, 0);
          check_val($sformatf("i%0d_rst_fwd_hit", g), bus.o_fwd_hit, 0);
          rst_seen = 1'b0;
        end
        check_val($sformatf("i%0d_hit_cnt", g), bus.o_fwd_hit_cnt, exp_cnt);
        if (bus.o_app_vld === 1'b1 && exp_rd_q.size() != 0) begin
          er = exp_rd_q.pop_front(); eh = exp_hit_q.pop_front();
          d_draw = draw_q.pop_front(); d_cal = cal_q.pop_front();
          check_val($sformatf("i%0d_app_rdata", g), bus.o_app_rdata, er);
          check_val($sformatf("i%0d_fwd_hit", g), bus.o_fwd_hit, eh);
          bus.i_app_wdata = bus.o_app_rdata + 1'b1;
          bus.i_draw_back = d_draw;
          bus.i_app_cal_data = d_cal;
          if (eh && exp_cnt != '1) exp_cnt++;
        end else begin
          check_val($sformatf("i%0d_app_vld_unexp", g), bus.o_app_vld, 0);
          check_val($sformatf("i%0d_idle_fwd_hit", g), bus.o_fwd_hit, 0);
          bus.i_draw_back = 1'($urandom_range(0, 1));
          bus.i_app_wdata = DW'($urandom);
          bus.i_app_cal_data = CW'($urandom);
        end
        if (bus.o_mem_wvld === 1'b1 && exp_wr_q.size() != 0) begin
          w = exp_wr_q.pop_front();
          check_val($sformatf("i%0d_waddr", g), bus.o_mem_waddr, w[PW+DW-1:DW]);
          check_val($sformatf("i%0d_wdata", g), bus.o_mem_wdata, w[DW-1:0]);
        end else begin
          check_val($sformatf("i%0d_wvld_unexp", g), bus.o_mem_wvld, 0);
        end
        if (bus.o_down_vld === 1'b1 && exp_dn_q.size() != 0) begin
          check_val($sformatf("i%0d_down_cal", g), bus.o_down_cal_data, exp_dn_q.pop_front());
        end else begin
          check_val($sformatf("i%0d_down_vld_unexp", g), bus.o_down_vld, 0);
        end
        if (drain_chk) begin
          check_val($sformatf("i%0d_rd_left", g), exp_rd_q.size(), 0);
          check_val($sformatf("i%0d_wr_left", g), exp_wr_q.size(), 0);
          check_val($sformatf("i%0d_dn_left", g), exp_dn_q.size(), 0);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input int id, input bit draw);
    drv_vld = 1'b1;
    drv_id = PW'(id);
    drv_draw = draw;
    drv_cal = CW'($urandom);
    @(posedge clk);
    #1;
    drv_vld = 1'b0;
  endtask

  task automatic preload(input int addr, input int data);
    pre_we = 1'b1;
    pre_addr = PW'(addr);
    pre_data = DW'(data);
    @(posedge clk);
    #1;
    pre_we = 1'b0;
  endtask

  initial begin
    int sel;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int p = 0; p < PN; p++) preload(p, $urandom_range(0, 1000));

    // back-to-back on one port: reads 5,6,7 with forwarding
    preload(3, 5);
    issue(3, 1'b0); issue(3, 1'b0); issue(3, 1'b0);
    idle(8);
    check_val("s1_cnt_lat2", cnt_obs[0], 2);
    check_val("s1_cnt_lat1", cnt_obs[1], 2);
    check_val("s1_cnt_nofwd", cnt_obs[2], 0);

    // middle op draws back; third op must see the first op's value
    preload(4, 5);
    issue(4, 1'b0); issue(4, 1'b1); issue(4, 1'b0);
    idle(8);
    check_val("s2_cnt_lat2", cnt_obs[0], 4);

    // spacing beyond the hazard window reads memory
    preload(3, 40);
    issue(3, 1'b0); idle(3); issue(3, 1'b0);
    idle(8);

    preload(1, 10); preload(2, 20);
    issue(1, 1'b0); issue(2, 1'b0); issue(1, 1'b0); issue(2, 1'b0);
    idle(8);

    repeat (120) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else begin
        sel = $urandom_range(0, 4);
        issue((sel == 4) ? int'($urandom_range(0, PN - 1)) : ((sel == 3) ? PN - 1 : sel),
              $urandom_range(0, 3) == 0);
      end
    end
    idle(8);

    // reset while three ops are in flight
    issue(5, 1'b0); issue(5, 1'b0); issue(5, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(6);
    for (int k = 0; k < NI; k++) check_val($sformatf("rst_cnt_i%0d", k), cnt_obs[k], 0);
    issue(5, 1'b0);
    idle(8);

    drain_chk = 1'b1;
    @(posedge clk);
    #1 drain_chk = 1'b0;
    idle(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
